stream_demux_1xn: RTL
=====================

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter N_CH, default 4, number of output channels (2..16).
REQ-003 Parameter SEL_W, default $clog2(N_CH), select width (derived, not overridden).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_sel  input  SEL_W  destination channel of the word.
REQ-010 out_valid  output  N_CH  per-channel word present; at most one bit set.
REQ-011 out_ready  input  N_CH  per-channel downstream acceptance.
REQ-012 out_data  output  N_CH*DATA_W  flattened per-channel payload; lane i = bits [i*DATA_W +: DATA_W].
REQ-013 drop_cnt  output  8  saturating count of words dropped for out-of-range in_sel.

Function
REQ-014 The block SHALL hold one registered output slot (full flag, stored data, stored select).
REQ-015 in_ready SHALL equal (slot empty) OR (out_ready of the stored channel), combinationally.
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-017 An accepted word with in_sel < N_CH SHALL appear on its channel the next cycle (latency 1).
REQ-018 out_valid[i] SHALL be 1 only when the slot is full and the stored select equals i.
REQ-019 Lane i of out_data SHALL carry stored data when out_valid[i]=1 and all-zero otherwise.
REQ-020 While out_valid[i]=1 and out_ready[i]=0, the slot SHALL hold data and select unchanged.
REQ-021 The slot SHALL empty on out_valid[i] AND out_ready[i] unless a new word is accepted in the same cycle.
REQ-022 Simultaneous drain and accept SHALL reload the slot with no bubble, giving one word per cycle sustained throughput.
REQ-023 out_ready of non-selected channels SHALL have no effect.
REQ-024 An accepted word with in_sel >= N_CH SHALL be discarded, never load the slot, and increment drop_cnt.
REQ-025 drop_cnt SHALL saturate at 255 and never wrap.
REQ-026 A discarded word accepted while the slot drains SHALL leave the slot empty next cycle.
REQ-027 in_data and in_sel SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst_n=0 at a rising edge: slot empty, stored data and select zero, drop_cnt zero.
REQ-029 While rst_n=0, in_ready SHALL be 0 and out_valid all-zero.
REQ-030 Reset asserted mid-transfer SHALL discard the held word with no output handshake completing.
REQ-031 The first word SHALL be accepted on the first rising edge after rst_n returns to 1.

Structure
REQ-032 Shared package demux_pkg SHALL hold DROP_CNT_W=8 and DROP_CNT_MAX=255.
REQ-033 The output slot SHALL be a sub-module demux_slot_reg (data + select + full, load/clear controls); the top holds decode, handshake, and drop counter.

Verification
REQ-034 Reset: rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, drop_cnt=0.
REQ-035 Single route: DATA_W=8, N_CH=4, send 0xA5 sel=2, out_ready=all 1 -> next cycle out_valid=0100, lane2=0xA5, lanes 0,1,3=0.
REQ-036 Backpressure: sel=1, out_ready[1]=0 for 5 cycles -> lane1 holds data, in_ready=0; raise out_ready[1] -> drains, in_ready=1 same cycle.
REQ-037 Streaming: 8 words, sel cycling 0..3, all ready -> one word per cycle on channels 0,1,2,3,0,1,2,3 in order, no bubbles.
REQ-038 Drop: N_CH=3, send 300 words with sel=3 -> out_valid never set, drop_cnt=255 and holds.
REQ-039 Reset mid-operation: slot full and stalled, pulse rst_n=0 one cycle -> out_valid=0 afterwards, held word never delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_slot_reg.sv
// Single registered output slot: payload, destination select and a full flag.
// load has priority over clear so a same-cycle drain and refill leaves it full.
module demux_slot_reg #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              full,
    output logic [DATA_W-1:0] q_data,
    output logic [SEL_W-1:0]  q_sel
);

    // Slot storage: reset empties and zeroes, load captures a word, clear empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= 1'b0;
            q_data <= '0;
            q_sel  <= '0;
        end else if (load) begin
            full   <= 1'b1;
            q_data <= d_data;
            q_sel  <= d_sel;
        end else if (clear) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1xn.sv
// 1-to-N stream demultiplexer with a single output slot.
// Words addressed to a non-existent channel are accepted and discarded,
// and counted in a saturating drop counter.
module stream_demux_1xn
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic              slot_full;
    logic [DATA_W-1:0] slot_data;
    logic [SEL_W-1:0]  slot_sel;
    logic              stored_ready;
    logic              sel_in_range;
    logic              accept;
    logic              drain;
    logic              load;
    logic              clear;

    // Ready of the channel the held word is waiting on; other channels are ignored.
    always_comb begin
        stored_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (slot_sel == SEL_W'(i)) stored_ready = out_ready[i];
        end
    end

    assign sel_in_range = ({1'b0, in_sel} < (SEL_W + 1)'(N_CH));
    assign in_ready     = rst_n & (~slot_full | stored_ready);
    assign accept       = in_valid & in_ready;
    assign drain        = rst_n & slot_full & stored_ready;
    assign load         = accept & sel_in_range;
    assign clear        = drain & ~load;

    demux_slot_reg #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .clear  (clear),
        .d_data (in_data),
        .d_sel  (in_sel),
        .full   (slot_full),
        .q_data (slot_data),
        .q_sel  (slot_sel)
    );

    // Decode the slot onto its channel; idle lanes are driven to zero.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rst_n && slot_full && (slot_sel == SEL_W'(i))) begin
                out_valid[i]                  = 1'b1;
                out_data[i*DATA_W +: DATA_W] = slot_data;
            end
        end
    end

    // Count accepted words whose select names no channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !sel_in_range) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule
